// File: rtl/cond_exec_stage.sv
// Conditional-execute pipeline stage: evaluates the ARM condition field against the
// committed flags, gates side-effect enables, and holds one beat behind a valid/ready handshake.
module cond_exec_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            Cond,
    input  logic [DATA_WIDTH-1:0] Result,
    input  logic                  N,
    input  logic                  Z,
    input  logic                  C,
    input  logic                  V,
    input  logic                  FlagUpdate,
    input  logic                  RegWrite_in,
    input  logic                  MemWrite_in,
    input  logic                  PCSrc_in,
    input  logic [3:0]            Rd_in,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_Result,
    output logic [3:0]            out_Rd,
    output logic                  out_RegWrite,
    output logic                  out_MemWrite,
    output logic                  out_PCSrc,
    output logic                  CondEx,
    output logic [3:0]            Flags,
    output logic [15:0]           annul_cnt
);

    // Odd codes are the complement of the even code below them; this also makes 1111 "never".
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n_f;
        logic z_f;
        logic c_f;
        logic v_f;
        logic base;
        {n_f, z_f, c_f, v_f} = nzcv;
        case (cond[3:1])
            3'd0:    base = z_f;
            3'd1:    base = c_f;
            3'd2:    base = n_f;
            3'd3:    base = v_f;
            3'd4:    base = c_f & ~z_f;
            3'd5:    base = (n_f == v_f);
            3'd6:    base = ~z_f & (n_f == v_f);
            3'd7:    base = 1'b1;
            default: base = 1'b0;
        endcase
        return base ^ cond[0];
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] res;
        if (value == 16'hFFFF) begin
            res = value;
        end else begin
            res = value + 16'd1;
        end
        return res;
    endfunction

    logic                  out_valid_r;
    logic [DATA_WIDTH-1:0] out_result_r;
    logic [3:0]            out_rd_r;
    logic                  out_regwrite_r;
    logic                  out_memwrite_r;
    logic                  out_pcsrc_r;
    logic                  condex_r;
    logic [3:0]            flags_r;
    logic [15:0]           annul_cnt_r;

    logic                  in_ready_s;
    logic                  xfer_s;
    logic                  pass_s;
    logic                  out_valid_nxt_s;
    logic [DATA_WIDTH-1:0] out_result_nxt_s;
    logic [3:0]            out_rd_nxt_s;
    logic                  out_regwrite_nxt_s;
    logic                  out_memwrite_nxt_s;
    logic                  out_pcsrc_nxt_s;
    logic                  condex_nxt_s;
    logic [3:0]            flags_nxt_s;
    logic [15:0]           annul_cnt_nxt_s;

    assign in_ready_s = (~out_valid_r | out_ready) & ~flush;
    assign xfer_s     = in_valid & in_ready_s;
    assign pass_s     = cond_pass(Cond, flags_r);

    // Next-state selection: flush, then transfer, then downstream drain, else hold.
    always_comb begin
        out_valid_nxt_s    = out_valid_r;
        out_result_nxt_s   = out_result_r;
        out_rd_nxt_s       = out_rd_r;
        out_regwrite_nxt_s = out_regwrite_r;
        out_memwrite_nxt_s = out_memwrite_r;
        out_pcsrc_nxt_s    = out_pcsrc_r;
        condex_nxt_s       = condex_r;
        flags_nxt_s        = flags_r;
        annul_cnt_nxt_s    = annul_cnt_r;
        if (flush) begin
            out_valid_nxt_s    = 1'b0;
            out_regwrite_nxt_s = 1'b0;
            out_memwrite_nxt_s = 1'b0;
            out_pcsrc_nxt_s    = 1'b0;
        end else if (xfer_s) begin
            out_valid_nxt_s    = 1'b1;
            out_result_nxt_s   = Result;
            out_rd_nxt_s       = Rd_in;
            out_regwrite_nxt_s = RegWrite_in & pass_s;
            out_memwrite_nxt_s = MemWrite_in & pass_s;
            out_pcsrc_nxt_s    = PCSrc_in & pass_s;
            condex_nxt_s       = pass_s;
            if (pass_s && FlagUpdate) begin
                flags_nxt_s = {N, Z, C, V};
            end else begin
                flags_nxt_s = flags_r;
            end
            if (!pass_s) begin
                annul_cnt_nxt_s = sat_inc16(annul_cnt_r);
            end else begin
                annul_cnt_nxt_s = annul_cnt_r;
            end
        end else if (out_ready) begin
            // Held beat drains with nothing behind it; enables drop with out_valid.
            out_valid_nxt_s    = 1'b0;
            out_regwrite_nxt_s = 1'b0;
            out_memwrite_nxt_s = 1'b0;
            out_pcsrc_nxt_s    = 1'b0;
        end else begin
            out_valid_nxt_s = out_valid_r;
        end
    end

    // Stage registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r    <= 1'b0;
            out_result_r   <= '0;
            out_rd_r       <= 4'd0;
            out_regwrite_r <= 1'b0;
            out_memwrite_r <= 1'b0;
            out_pcsrc_r    <= 1'b0;
            condex_r       <= 1'b0;
            flags_r        <= 4'd0;
            annul_cnt_r    <= 16'd0;
        end else begin
            out_valid_r    <= out_valid_nxt_s;
            out_result_r   <= out_result_nxt_s;
            out_rd_r       <= out_rd_nxt_s;
            out_regwrite_r <= out_regwrite_nxt_s;
            out_memwrite_r <= out_memwrite_nxt_s;
            out_pcsrc_r    <= out_pcsrc_nxt_s;
            condex_r       <= condex_nxt_s;
            flags_r        <= flags_nxt_s;
            annul_cnt_r    <= annul_cnt_nxt_s;
        end
    end

    assign in_ready     = in_ready_s;
    assign out_valid    = out_valid_r;
    assign out_Result   = out_result_r;
    assign out_Rd       = out_rd_r;
    assign out_RegWrite = out_regwrite_r;
    assign out_MemWrite = out_memwrite_r;
    assign out_PCSrc    = out_pcsrc_r;
    assign CondEx       = condex_r;
    assign Flags        = flags_r;
    assign annul_cnt    = annul_cnt_r;

endmodule
